alu_md_ctrl: RTL and testbench
==============================

Name: alu_md_ctrl

Overview:
Next-generation ALU control for the MIPS datapath. It widens the ALU control code to 4 bits to add xor/nor/shift/sltu, and it flags undefined funct codes instead of holding the previous value. It also owns the HI/LO register pair and an iterative multiply/divide sequencer, with a start/busy/done handshake and a stall request toward the pipeline control. It sits between the main control unit and the ALU/register-file write-back mux.

Parameters:
WIDTH, 32, operand/HI/LO width; even, >= 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
alu_op  in  2  class from main control
funct  in  6  instruction funct field
op_valid  in  1  current instruction is valid (qualifies MD start and HI/LO moves)
a  in  WIDTH  rs operand
b  in  WIDTH  rt operand
alu_ctrl  out  4  ALU operation code (combinational)
illegal  out  1  alu_op=10 with an undefined funct (combinational)
md_busy  out  1  sequencer not idle
md_done  out  1  one-cycle pulse: HI/LO just updated by mult/div
stall  out  1  pipeline stall request (combinational)
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
mf_data  out  WIDTH  mfhi→hi, mflo→lo, else 0

Behaviour:
- Decode, all combinational:
  - alu_op 00→0100 (add); 01→0110 (sub); 11→0001 (or, ori/lui).
  - alu_op 10, funct: 100000→0100 add, 100001→0101 addu, 100010→0110 sub, 100100→0000 and, 100101→0001 or, 100110→0010 xor, 100111→0111 nor, 101010→0011 slt, 101011→1011 sltu, 000000→1000 sll, 000010→1001 srl, 000011→1010 sra.
  - MD/move functs (011000–011011, 010000–010011) → 0100 with illegal=0.
  - Any other funct → 0100 with illegal=1.
- MD functs: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo. MD action requires alu_op=10 and op_valid=1.
- States: IDLE, CALC, FIX, DONE. md_busy = (state != IDLE). md_done = (state == DONE).
- Accept: in IDLE, a mult/div request is accepted at edge E0. Operand magnitudes (signed ops) or raw values (unsigned) and the sign flags are latched. Counter=WIDTH. State→CALC.
- CALC: one shift-add (mult) or restoring-subtract (div) step per edge. After WIDTH steps (edge E_WIDTH) state→FIX.
- FIX: at E_WIDTH+1 the sign correction is applied and hi/lo are written. State→DONE.
  - mult: {hi,lo} = 2·WIDTH product, negated if signs differ (signed only).
  - div: lo=quotient, hi=remainder. Quotient is negated if signs differ; remainder takes the dividend sign.
- DONE: md_done=1 for exactly one cycle, then IDLE. Total latency accept→done cycle = WIDTH+2 cycles.
- Divide by zero (b=0): accepted, CALC/FIX skipped. At E1: hi=a, lo=all ones, state→DONE.
- Signed MIN/-1: no special case. Result lo=MIN, hi=0 falls out of the magnitude algorithm.
- A mult/div request while md_busy is ignored (not queued), and stall=1.
- mfhi/mflo/mthi/mtlo while md_busy: stall=1, and the mthi/mtlo write is suppressed.
- mthi/mtlo in IDLE write hi/lo from a at the edge.
- mf_data is combinational from the current hi/lo.
- Otherwise stall=0.
- Reset (any time, including mid-CALC): state=IDLE, hi=lo=0, counter/temporaries=0. md_busy=0, md_done=0, stall=0 immediately on rst_n low. The in-flight operation is discarded.
- Operands are not required stable after accept.

Test Plan:
- Decode sweep: alu_op=10 with every listed funct → listed code and illegal=0; funct=111111 → 0100 with illegal=1; alu_op 00/01/11 → 0100/0110/0001.
- mult a=FFFFFFFF, b=00000002 (WIDTH=32): md_done exactly 34 cycles after accept; hi=FFFFFFFF, lo=FFFFFFFE. Same operands with multu → hi=00000001, lo=FFFFFFFE.
- div a=FFFFFFF9 (-7), b=00000002 → lo=FFFFFFFD, hi=FFFFFFFF. divu 00000007/00000002 → lo=3, hi=1. div 80000000/FFFFFFFF → lo=80000000, hi=0.
- div a=12345678, b=0 → md_done one cycle after accept; hi=12345678, lo=FFFFFFFF.
- Second mult issued at cycle 5 of a busy op → stall=1, ignored, first result intact. mfhi during busy → stall=1. mthi 0000ABCD in IDLE → hi=0000ABCD next edge, mf_data follows on mfhi.
- rst_n low at cycle 10 of a div → md_busy=0 and hi=lo=0 asynchronously. After release a new mult completes normally.

Source files
------------

// File: rtl/alu_md_if.sv
// Bundle of decode inputs and multiply/divide results between pipeline control and alu_md_ctrl.
interface alu_md_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic             op_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctrl;
  logic             illegal;
  logic             md_busy;
  logic             md_done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;

  modport master (
    output alu_op, funct, op_valid, a, b,
    input  alu_ctrl, illegal, md_busy, md_done, stall, hi, lo, mf_data
  );

  modport slave (
    input  alu_op, funct, op_valid, a, b,
    output alu_ctrl, illegal, md_busy, md_done, stall, hi, lo, mf_data
  );
endinterface

// File: rtl/alu_md_ctrl.sv
// ALU control decode plus HI/LO registers with an iterative shift-add / restoring-divide sequencer.
module alu_md_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  alu_md_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_acc, r_q, r_m;
  logic             r_is_div, r_dz, r_neg_q, r_neg_r;

  logic [3:0]       w_alu_ctrl;
  logic             w_illegal;
  logic             w_md_op, w_mult_div, w_move, w_signed;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_sum, w_shl;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  always_comb begin
    w_alu_ctrl = 4'b0100;
    w_illegal  = 1'b0;
    unique case (bus.alu_op)
      2'b00: w_alu_ctrl = 4'b0100;
      2'b01: w_alu_ctrl = 4'b0110;
      2'b11: w_alu_ctrl = 4'b0001;
      default: begin
        case (bus.funct)
          6'b100000: w_alu_ctrl = 4'b0100;
          6'b100001: w_alu_ctrl = 4'b0101;
          6'b100010: w_alu_ctrl = 4'b0110;
          6'b100100: w_alu_ctrl = 4'b0000;
          6'b100101: w_alu_ctrl = 4'b0001;
          6'b100110: w_alu_ctrl = 4'b0010;
          6'b100111: w_alu_ctrl = 4'b0111;
          6'b101010: w_alu_ctrl = 4'b0011;
          6'b101011: w_alu_ctrl = 4'b1011;
          6'b000000: w_alu_ctrl = 4'b1000;
          6'b000010: w_alu_ctrl = 4'b1001;
          6'b000011: w_alu_ctrl = 4'b1010;
          6'b011000, 6'b011001, 6'b011010, 6'b011011,
          6'b010000, 6'b010001, 6'b010010, 6'b010011: w_alu_ctrl = 4'b0100;
          default: w_illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign w_md_op    = bus.op_valid && (bus.alu_op == 2'b10);
  assign w_mult_div = w_md_op && (bus.funct[5:2] == 4'b0110);
  assign w_move     = w_md_op && (bus.funct[5:2] == 4'b0100);
  assign w_signed   = ~bus.funct[0];
  assign w_mag_a    = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_mag_b    = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Step datapath: {r_acc,r_q} is the product / remainder:dividend pair.
  assign w_sum      = r_q[0] ? ({1'b0, r_acc} + {1'b0, r_m}) : {1'b0, r_acc};
  assign w_shl      = {r_acc, r_q[WIDTH-1]};
  assign w_ge       = (w_shl >= {1'b0, r_m});
  assign w_sub      = w_shl[WIDTH-1:0] - r_m;
  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_mult_div) w_state_nxt = StCalc;
      StCalc: begin
        if (r_dz) w_state_nxt = StDone;
        else if (r_cnt == CNT_W'(1)) w_state_nxt = StFix;
      end
      StFix:  w_state_nxt = StDone;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_mult_div) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_is_div <= bus.funct[1];
            r_dz     <= bus.funct[1] && (bus.b == '0);
            // Divide-by-zero parks the raw dividend in r_acc for the HI write.
            r_acc    <= (bus.funct[1] && (bus.b == '0)) ? bus.a : '0;
            r_q      <= w_mag_a;
            r_m      <= w_mag_b;
            r_neg_q  <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r  <= w_signed && bus.a[WIDTH-1];
          end else if (w_move && bus.funct == 6'b010001) begin
            r_hi <= bus.a;
          end else if (w_move && bus.funct == 6'b010011) begin
            r_lo <= bus.a;
          end
        end
        StCalc: begin
          if (r_dz) begin
            r_hi <= r_acc;
            r_lo <= '1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_is_div) begin
              r_acc <= w_ge ? w_sub : w_shl[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], w_ge};
            end else begin
              r_acc <= w_sum[WIDTH:1];
              r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            end
          end
        end
        StFix: begin
          if (r_is_div) begin
            r_hi <= r_neg_r ? -r_acc : r_acc;
            r_lo <= r_neg_q ? -r_q : r_q;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_ctrl = w_alu_ctrl;
  assign bus.illegal  = w_illegal;
  assign bus.md_busy  = (r_state != StIdle);
  assign bus.md_done  = (r_state == StDone);
  assign bus.stall    = (r_state != StIdle) && (w_mult_div || w_move);
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.mf_data  = (bus.alu_op == 2'b10 && bus.funct == 6'b010000) ? r_hi :
                        (bus.alu_op == 2'b10 && bus.funct == 6'b010010) ? r_lo : '0;
endmodule

// File: tb/tb_alu_md_ctrl.sv
// Directed bench for alu_md_ctrl: decode sweep, mult/div results and latency, busy/stall, reset.
module tb_alu_md_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_md_if #(.WIDTH(32)) bus ();

  alu_md_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] f_tab [20];
  logic [3:0] c_tab [20];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enters at posedge+1; the accept edge is the first edge; latency counts edges after it.
  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    n = 0;
    bus.alu_op = 2'b10; bus.funct = f; bus.a = av; bus.b = bv; bus.op_valid = 1'b1;
    step();
    bus.op_valid = 1'b0; bus.a = 32'h5a5a_5a5a; bus.b = 32'hc3c3_c3c3;
    chk({tag, "_busy"}, 64'(bus.md_busy), 64'd1);
    while (bus.md_done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_n));
    chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    step();
    chk({tag, "_idle"}, 64'(bus.md_busy), 64'd0);
  endtask

  initial begin
    int n;
    f_tab[0]  = 6'b100000; c_tab[0]  = 4'b0100;
    f_tab[1]  = 6'b100001; c_tab[1]  = 4'b0101;
    f_tab[2]  = 6'b100010; c_tab[2]  = 4'b0110;
    f_tab[3]  = 6'b100100; c_tab[3]  = 4'b0000;
    f_tab[4]  = 6'b100101; c_tab[4]  = 4'b0001;
    f_tab[5]  = 6'b100110; c_tab[5]  = 4'b0010;
    f_tab[6]  = 6'b100111; c_tab[6]  = 4'b0111;
    f_tab[7]  = 6'b101010; c_tab[7]  = 4'b0011;
    f_tab[8]  = 6'b101011; c_tab[8]  = 4'b1011;
    f_tab[9]  = 6'b000000; c_tab[9]  = 4'b1000;
    f_tab[10] = 6'b000010; c_tab[10] = 4'b1001;
    f_tab[11] = 6'b000011; c_tab[11] = 4'b1010;
    f_tab[12] = 6'b011000; c_tab[12] = 4'b0100;
    f_tab[13] = 6'b011001; c_tab[13] = 4'b0100;
    f_tab[14] = 6'b011010; c_tab[14] = 4'b0100;
    f_tab[15] = 6'b011011; c_tab[15] = 4'b0100;
    f_tab[16] = 6'b010000; c_tab[16] = 4'b0100;
    f_tab[17] = 6'b010001; c_tab[17] = 4'b0100;
    f_tab[18] = 6'b010010; c_tab[18] = 4'b0100;
    f_tab[19] = 6'b010011; c_tab[19] = 4'b0100;

    rst_n = 1'b0;
    bus.alu_op = 2'b00; bus.funct = 6'b0; bus.op_valid = 1'b0; bus.a = '0; bus.b = '0;
    #2;
    chk("rst_busy", 64'(bus.md_busy), 64'd0);
    chk("rst_done", 64'(bus.md_done), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep with op_valid low so no MD side effects.
    bus.alu_op = 2'b10;
    for (int i = 0; i < 20; i++) begin
      bus.funct = f_tab[i];
      #1;
      chk($sformatf("dec_ctrl_%b", f_tab[i]), 64'(bus.alu_ctrl), 64'(c_tab[i]));
      chk($sformatf("dec_ill_%b", f_tab[i]), 64'(bus.illegal), 64'd0);
    end
    bus.funct = 6'b111111;
    #1;
    chk("dec_ctrl_undef", 64'(bus.alu_ctrl), 64'h4);
    chk("dec_ill_undef", 64'(bus.illegal), 64'd1);
    bus.alu_op = 2'b00; #1; chk("dec_op00", 64'(bus.alu_ctrl), 64'h4);
    chk("dec_op00_ill", 64'(bus.illegal), 64'd0);
    bus.alu_op = 2'b01; #1; chk("dec_op01", 64'(bus.alu_ctrl), 64'h6);
    bus.alu_op = 2'b11; #1; chk("dec_op11", 64'(bus.alu_ctrl), 64'h1);
    step();

    // Latency 33 edges after the accept edge = done in the 34th cycle counting the accept cycle.
    run_md("mult",  6'b011000, 32'hffff_ffff, 32'h0000_0002, 33, 32'hffff_ffff, 32'hffff_fffe);
    run_md("multu", 6'b011001, 32'hffff_ffff, 32'h0000_0002, 33, 32'h0000_0001, 32'hffff_fffe);
    run_md("div",   6'b011010, 32'hffff_fff9, 32'h0000_0002, 33, 32'hffff_ffff, 32'hffff_fffd);
    run_md("divu",  6'b011011, 32'h0000_0007, 32'h0000_0002, 33, 32'h0000_0001, 32'h0000_0003);
    run_md("divmin", 6'b011010, 32'h8000_0000, 32'hffff_ffff, 33, 32'h0000_0000, 32'h8000_0000);
    run_md("div0",  6'b011010, 32'h1234_5678, 32'h0000_0000, 1, 32'h1234_5678, 32'hffff_ffff);

    // Busy: second mult ignored, mfhi/mthi stall, mthi write suppressed.
    bus.alu_op = 2'b10; bus.funct = 6'b011000; bus.a = 32'd3; bus.b = 32'd5; bus.op_valid = 1'b1;
    step();
    bus.op_valid = 1'b0;
    repeat (4) step();
    bus.funct = 6'b011000; bus.a = 32'd7; bus.b = 32'd7; bus.op_valid = 1'b1;
    #1;
    chk("busy_mult_stall", 64'(bus.stall), 64'd1);
    step();
    bus.funct = 6'b010000;
    #1;
    chk("busy_mfhi_stall", 64'(bus.stall), 64'd1);
    bus.funct = 6'b010001; bus.a = 32'hdead_beef;
    #1;
    chk("busy_mthi_stall", 64'(bus.stall), 64'd1);
    step();
    bus.op_valid = 1'b0;
    #1;
    chk("busy_no_req_stall", 64'(bus.stall), 64'd0);
    n = 0;
    while (bus.md_done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("busy_done_seen", 64'(bus.md_done), 64'd1);
    chk("busy_first_hi", 64'(bus.hi), 64'd0);
    chk("busy_first_lo", 64'(bus.lo), 64'd15);
    step();
    chk("busy_ignored_idle", 64'(bus.md_busy), 64'd0);

    // Moves in IDLE.
    bus.alu_op = 2'b10; bus.funct = 6'b010001; bus.a = 32'h0000_abcd; bus.op_valid = 1'b1;
    #1;
    chk("mthi_stall", 64'(bus.stall), 64'd0);
    step();
    chk("mthi_hi", 64'(bus.hi), 64'h0000_abcd);
    bus.funct = 6'b010000;
    #1;
    chk("mfhi_data", 64'(bus.mf_data), 64'h0000_abcd);
    chk("mfhi_stall", 64'(bus.stall), 64'd0);
    bus.funct = 6'b010011; bus.a = 32'h0000_1234;
    step();
    chk("mtlo_lo", 64'(bus.lo), 64'h0000_1234);
    chk("mtlo_hi_kept", 64'(bus.hi), 64'h0000_abcd);
    bus.funct = 6'b010010;
    #1;
    chk("mflo_data", 64'(bus.mf_data), 64'h0000_1234);
    bus.funct = 6'b100000;
    #1;
    chk("mf_other_zero", 64'(bus.mf_data), 64'd0);
    bus.op_valid = 1'b0;
    step();

    // Asynchronous reset in the middle of a divide.
    bus.funct = 6'b011010; bus.a = 32'd100; bus.b = 32'd7; bus.op_valid = 1'b1;
    step();
    bus.op_valid = 1'b0;
    repeat (9) step();
    chk("pre_rst_busy", 64'(bus.md_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.md_busy), 64'd0);
    chk("arst_done", 64'(bus.md_done), 64'd0);
    chk("arst_hi", 64'(bus.hi), 64'd0);
    chk("arst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_md("post_rst_mult", 6'b011000, 32'd6, 32'd7, 33, 32'd0, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
